// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// flags unsupported encodings and counts retired instructions.
module multicycle_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        PCEn,
   output logic        IorD,
   output logic        Memwrite,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        ALUsrcA,
   output logic [1:0]  ALUsrcB,
   output logic [2:0]  ALUControl,
   output logic        PCsrc,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] retired
);

   localparam int unsigned RW = 32;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_HALT     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [3:0]    state_q, state_d;
   logic          illegal_q, illegal_d;
   logic [RW-1:0] retired_q, retired_d;
   logic          funct_ok;
   logic          pc_write, branch;

   assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

   // Next-state, sticky illegal flag and retirement counter
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      retired_d = retired_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW)         state_d = S_MEMADR;
            else if (op == OP_RTYPE && funct_ok)    state_d = S_EXECUTE;
            else if (op == OP_BEQ)                  state_d = S_BRANCH;
            else if (op == OP_ADDI)                 state_d = S_ADDIEXEC;
            else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB: begin
            state_d   = S_FETCH;
            retired_d = retired_q + RW'(1);
         end
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Moore control decode; reset masks every strobe so nothing writes during reset
   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      IorD       = 1'b0;
      Memwrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUsrcA    = 1'b0;
      ALUsrcB    = 2'b00;
      ALUControl = 3'b010;
      PCsrc      = 1'b0;
      case (state_q)
         S_FETCH: begin
            IRWrite  = 1'b1;
            ALUsrcB  = 2'b01;
            pc_write = 1'b1;
         end
         S_DECODE:  ALUsrcB = 2'b11;
         S_MEMADR: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'b10;
         end
         S_MEMREAD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWRITE: begin
            IorD     = 1'b1;
            Memwrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUsrcA = 1'b1;
            case (funct)
               FN_SUB:  ALUControl = 3'b110;
               FN_AND:  ALUControl = 3'b000;
               FN_OR:   ALUControl = 3'b001;
               FN_SLT:  ALUControl = 3'b111;
               default: ALUControl = 3'b010;
            endcase
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUsrcA    = 1'b1;
            ALUControl = 3'b110;
            PCsrc      = 1'b1;
            branch     = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'b10;
         end
         S_ADDIWB:  RegWrite = 1'b1;
         S_HALT:    ;
         default:   ALUControl = 3'b000;
      endcase
      PCEn = pc_write | (branch & zero);
      if (rst) begin
         PCEn       = 1'b0;
         IorD       = 1'b0;
         Memwrite   = 1'b0;
         IRWrite    = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         RegWrite   = 1'b0;
         ALUsrcA    = 1'b0;
         ALUsrcB    = 2'b00;
         ALUControl = 3'b000;
         PCsrc      = 1'b0;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle comparison against an instruction-level model
// of the control sequence, plus a few literal pins of the model itself.
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0]  st;
      logic        pcen, iord, memw, irw, regdst, mtr, regw, srca;
      logic [1:0]  srcb;
      logic [2:0]  aluc;
      logic        pcsrc;
      logic        ill;
      logic [31:0] ret;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic        zero;
   logic        PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc;
   logic [1:0]  ALUsrcB;
   logic [2:0]  ALUControl;
   logic [3:0]  state;
   logic        illegal;
   logic [31:0] retired;

   int   checks = 0;
   int   failures = 0;
   obs_t act, exp_o;
   logic exp_valid = 1'b0;
   logic        m_ill;
   logic [31:0] m_ret;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .PCEn(PCEn), .IorD(IorD), .Memwrite(Memwrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUControl(ALUControl),
      .PCsrc(PCsrc), .state(state), .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   always_comb begin
      act        = '0;
      act.st     = state;
      act.pcen   = PCEn;
      act.iord   = IorD;
      act.memw   = Memwrite;
      act.irw    = IRWrite;
      act.regdst = RegDst;
      act.mtr    = MemtoReg;
      act.regw   = RegWrite;
      act.srca   = ALUsrcA;
      act.srcb   = ALUsrcB;
      act.aluc   = ALUControl;
      act.pcsrc  = PCsrc;
      act.ill    = illegal;
      act.ret    = retired;
   end

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, a, e);
      end
   endtask

   always @(negedge clk) if (exp_valid) chk("cycle", 64'(act), 64'(exp_o));

   // Expected observation for one cycle in a given phase of an instruction
   function automatic obs_t ctl(input int ph, input logic [5:0] fn, input logic z,
                                input logic in_rst);
      obs_t e = '0;
      e.st  = 4'(ph);
      e.ill = m_ill;
      e.ret = m_ret;
      if (in_rst) return e;
      e.aluc = 3'b010;
      case (ph)
         0: begin e.irw = 1; e.srcb = 2'd1; e.pcen = 1; end
         1: e.srcb = 2'd3;
         2: begin e.srca = 1; e.srcb = 2'd2; end
         3: e.iord = 1;
         4: begin e.mtr = 1; e.regw = 1; end
         5: begin e.iord = 1; e.memw = 1; end
         6: begin
            e.srca = 1;
            if (fn == 6'b100010)      e.aluc = 3'b110;
            else if (fn == 6'b100100) e.aluc = 3'b000;
            else if (fn == 6'b100101) e.aluc = 3'b001;
            else if (fn == 6'b101010) e.aluc = 3'b111;
         end
         7: begin e.regdst = 1; e.regw = 1; end
         8: begin e.srca = 1; e.aluc = 3'b110; e.pcsrc = 1; e.pcen = z; end
         9: begin e.srca = 1; e.srcb = 2'd2; end
         10: e.regw = 1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic cyc(input obs_t e);
      exp_o     = e;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input int cur_ph);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc(ctl(cur_ph, funct, 1'b0, 1'b1));
         cur_ph = 0;
         m_ret  = '0;
         m_ill  = 1'b0;
      end
      rst = 1'b0;
   endtask

   // Runs one instruction; abort >= 0 asserts a 2-cycle reset in that phase index
   task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input logic z,
                            input int abort, input int halt_cycles);
      int  q[$];
      logic legal = 1'b1;
      op    = o;
      funct = fn;
      q = {0, 1};
      if (o == 6'b100011)      q = {0, 1, 2, 3, 4};
      else if (o == 6'b101011) q = {0, 1, 2, 5};
      else if (o == 6'b000100) q = {0, 1, 8};
      else if (o == 6'b001000) q = {0, 1, 9, 10};
      else if (o == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                  fn == 6'b100101 || fn == 6'b101010))
         q = {0, 1, 6, 7};
      else legal = 1'b0;
      foreach (q[i]) begin
         zero = (q[i] == 8) ? z : 1'($urandom);
         if (i == abort) begin
            do_reset(2, q[i]);
            return;
         end
         cyc(ctl(q[i], fn, z, 1'b0));
      end
      if (legal) m_ret = m_ret + 32'd1;
      else begin
         m_ill = 1'b1;
         for (int k = 0; k < halt_cycles; k++) begin
            zero = 1'($urandom);
            cyc(ctl(11, fn, 1'b0, 1'b0));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; op = '0; funct = '0; zero = 1'b0;
      m_ret = '0; m_ill = 1'b0;
      @(posedge clk); #1;
      do_reset(1, 0);

      run_instr(6'b100011, 6'd0, 1'b0, -1, 0);
      chk("lw_retired", 64'(retired), 64'd1);
      run_instr(6'b000000, 6'b100010, 1'b0, -1, 0);
      run_instr(6'b000000, 6'b101010, 1'b0, -1, 0);
      run_instr(6'b000000, 6'b100000, 1'b0, -1, 0);
      run_instr(6'b000000, 6'b100100, 1'b0, -1, 0);
      run_instr(6'b000000, 6'b100101, 1'b0, -1, 0);
      run_instr(6'b001000, 6'd5, 1'b0, -1, 0);
      run_instr(6'b000100, 6'd0, 1'b1, -1, 0);
      run_instr(6'b000100, 6'd0, 1'b0, -1, 0);
      chk("beq_retired", 64'(retired), 64'd9);
      run_instr(6'b101011, 6'd0, 1'b0, -1, 0);

      // Reset mid-lw in MEMREAD, held 2 cycles
      run_instr(6'b100011, 6'd0, 1'b0, 3, 0);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      run_instr(6'b001000, 6'd0, 1'b0, -1, 0);

      // Counter wrap: preload all-ones across a non-counting edge
      force dut.retired_q = 32'hFFFF_FFFF;
      m_ret = 32'hFFFF_FFFF;
      fork
         begin @(negedge clk); @(negedge clk); release dut.retired_q; end
      join_none
      run_instr(6'b101011, 6'd0, 1'b0, -1, 0);
      chk("wrap_retired", 64'(retired), 64'd0);

      run_instr(6'b101011, 6'd0, 1'b0, 2, 0);
      chk("sw_abort_retired", 64'(retired), 64'd0);
      run_instr(6'b000000, 6'b100101, 1'b0, -1, 0);

      run_instr(6'b000010, 6'd0, 1'b0, -1, 20);
      chk("halt_state", 64'(state), 64'd11);
      chk("halt_illegal", 64'(illegal), 64'd1);
      chk("halt_retired", 64'(retired), 64'd1);
      do_reset(1, 11);
      chk("halt_clear", 64'(illegal), 64'd0);

      run_instr(6'b000000, 6'b000111, 1'b0, -1, 3);
      do_reset(1, 11);
      run_instr(6'b100011, 6'd0, 1'b0, -1, 0);
      cyc(ctl(0, funct, 1'b0, 1'b0));
      exp_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
